// File: rtl/pla_seq_engine.sv
// Runtime-loadable AND/OR plane evaluated through a two-stage valid/ready pipeline.
// Optional serial readback of the configuration chain: PLA_SEQ_READBACK_EN.
module pla_seq_engine #(
  parameter int N_IN    = 51,
  parameter int N_OUT   = 35,
  parameter int N_TERMS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_bit_valid,
  input  logic             cfg_bit,
  output logic             cfg_busy,
  output logic             cfg_sout,
  output logic             configured,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data
);

  localparam int unsigned TERM_W  = 2 * N_IN;
  localparam int unsigned OR_BASE = N_TERMS * TERM_W;
  localparam int          CFG_LEN = N_TERMS * 2 * N_IN + N_OUT * N_TERMS;
  localparam int          CW      = $clog2(CFG_LEN + 1);
  localparam logic [CW-1:0] CFG_LEN_C = CW'(CFG_LEN);

  typedef enum logic [1:0] {UNCFG, LOAD, RUN, DRAIN} state_t;

  state_t               state_q;
  logic [CFG_LEN-1:0]   chain_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic                 configured_q;
  logic                 busy_q;
  logic                 s1_valid_q;
  logic [N_TERMS-1:0]   term_q;
  logic                 s2_valid_q;
  logic [N_OUT-1:0]     out_q;

  logic                 s1_load;
  logic                 s2_load;
  logic                 accept;
  logic                 bit_acc;
  logic                 pipe_empty;
  logic [N_TERMS-1:0]   term_c;
  logic [N_OUT-1:0]     or_c;

  assign s2_load    = ~s2_valid_q | out_ready;
  assign s1_load    = ~s1_valid_q | s2_load;
  assign in_ready   = configured_q & s1_load;
  assign accept     = in_valid & in_ready;
  assign bit_acc    = (state_q == LOAD) & cfg_bit_valid;
  // A vector accepted in the cfg_start cycle must still drain before LOAD.
  assign pipe_empty = ~s1_valid_q & ~s2_valid_q & ~accept;
  assign cnt_d      = (cfg_start ? '0 : cnt_q) + CW'(bit_acc);

  assign configured = configured_q;
  assign cfg_busy   = busy_q;
  assign out_valid  = s2_valid_q;
  assign out_data   = out_q;

  always_comb begin
    term_c = '1;
    for (int unsigned t = 0; t < N_TERMS; t++) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if ((chain_q[t*TERM_W + i] & ~in_data[i]) |
            (chain_q[t*TERM_W + N_IN + i] & in_data[i]))
          term_c[t] = 1'b0;
      end
    end
  end

  always_comb begin
    or_c = '0;
    for (int unsigned o = 0; o < N_OUT; o++) begin
      for (int unsigned t = 0; t < N_TERMS; t++) begin
        if (term_q[t] & chain_q[OR_BASE + o*N_TERMS + t])
          or_c[o] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= UNCFG;
      chain_q      <= '0;
      cnt_q        <= '0;
      configured_q <= 1'b0;
      busy_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      term_q       <= '0;
      s2_valid_q   <= 1'b0;
      out_q        <= '0;
    end else begin
      if (bit_acc)
        chain_q <= {cfg_bit, chain_q[CFG_LEN-1:1]};
      if (s1_load) begin
        s1_valid_q <= accept;
        if (accept)
          term_q <= term_c;
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q)
          out_q <= or_c;
      end
      case (state_q)
        UNCFG: begin
          if (cfg_start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          cnt_q <= cnt_d;
          if (cnt_d == CFG_LEN_C) begin
            state_q      <= RUN;
            configured_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        RUN: begin
          if (cfg_start) begin
            state_q      <= pipe_empty ? LOAD : DRAIN;
            cnt_q        <= '0;
            configured_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        DRAIN: begin
          if (~s1_valid_q & ~s2_valid_q)
            state_q <= LOAD;
        end
        default: state_q <= UNCFG;
      endcase
    end
  end

`ifdef PLA_SEQ_READBACK_EN
  logic sout_q;
  always_ff @(posedge clk) begin
    if (rst)
      sout_q <= 1'b0;
    else if (bit_acc)
      sout_q <= chain_q[0];
  end
  assign cfg_sout = sout_q;
`else
  assign cfg_sout = 1'b0;
`endif

endmodule

// File: tb/tb_pla_seq_engine.sv
// Scoreboard bench for pla_seq_engine with a 4-input, 2-output, 3-term plane.
module tb_pla_seq_engine;

  localparam int N_IN    = 4;
  localparam int N_OUT   = 2;
  localparam int N_TERMS = 3;
  localparam int CFG_LEN = 30;

  // Bit j is chain index j (written j-th). A: t0=in0&~in1, t1=in2, out0=t0|t1, out1=t1.
  localparam logic [CFG_LEN-1:0] IMG_A = 30'h13000421;
  // B: same terms, out0=t2 (all-zero term), out1=t1.
  localparam logic [CFG_LEN-1:0] IMG_B = 30'h14000421;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_start = 1'b0;
  logic cfg_bit_valid = 1'b0;
  logic cfg_bit = 1'b0;
  logic cfg_busy, cfg_sout, configured;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N_IN-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [N_OUT-1:0] out_data;

  int unsigned cmp_cnt = 0;
  int unsigned err_cnt = 0;
  logic [N_OUT-1:0] exp_q[$];

  always #5 clk = ~clk;

  pla_seq_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid),
    .cfg_bit(cfg_bit), .cfg_busy(cfg_busy), .cfg_sout(cfg_sout),
    .configured(configured), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [N_OUT-1:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_out: got %0h expected none at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
        end
      end
    end
  endtask

  task automatic send(input logic [N_IN-1:0] v, input logic [N_OUT-1:0] e);
    int unsigned n = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    while (!done && n < 20) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL send_timeout: got no in_ready expected accept of %0h", v);
    end
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  // Shift an image in; old_img is the chain content expected to appear on cfg_sout.
  task automatic load_image(input logic [CFG_LEN-1:0] img, input logic [CFG_LEN-1:0] old_img);
    logic [CFG_LEN-1:0] o;
    o = old_img;
    for (int j = 0; j < CFG_LEN; j++) begin
      cfg_bit_valid = 1'b1;
      cfg_bit       = img[j];
      step();
`ifdef PLA_SEQ_READBACK_EN
      chk("cfg_sout", 32'(cfg_sout), 32'(o[j]));
`else
      if (j == 0) chk("cfg_sout_tied", 32'(cfg_sout), 32'd0);
`endif
      if (j == CFG_LEN - 2) chk("configured_before_last", 32'(configured), 32'd0);
    end
    cfg_bit_valid = 1'b0;
    cfg_bit       = 1'b0;
    chk("configured_after_load", 32'(configured), 32'd1);
    chk("in_ready_after_load", 32'(in_ready), 32'd1);
    chk("cfg_busy_after_load", 32'(cfg_busy), 32'd0);
  endtask

  initial begin
    logic [N_IN-1:0]  vec_a[4] = '{4'b0001, 4'b0100, 4'b0011, 4'b1000};
    logic [N_OUT-1:0] exp_a[4] = '{2'b01, 2'b11, 2'b00, 2'b00};
    int unsigned acc;

    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state, and an unconfigured engine never accepts.
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_configured", 32'(configured), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    chk("rst_cfg_sout", 32'(cfg_sout), 32'd0);
    in_valid = 1'b1;
    in_data  = 4'b0001;
    repeat (3) begin
      @(negedge clk);
      chk("uncfg_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Load image A.
    pulse_start();
    chk("load_cfg_busy", 32'(cfg_busy), 32'd1);
    chk("load_configured", 32'(configured), 32'd0);
    load_image(IMG_A, '0);

    // Config bits outside LOAD must not shift the chain.
    cfg_bit_valid = 1'b1;
    cfg_bit       = 1'b1;
    repeat (5) step();
    cfg_bit_valid = 1'b0;
    cfg_bit       = 1'b0;

    // Back-to-back stream with latency and throughput checks.
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_data  = vec_a[j];
      @(negedge clk);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      chk("stream_out_valid", 32'(out_valid), (j >= 2) ? 32'd1 : 32'd0);
      exp_q.push_back(exp_a[j]);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("stream_drained", exp_q.size(), 32'd0);

    // Backpressure: only two vectors fit.
    out_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1;
      in_data  = vec_a[j % 2];
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp_a[j % 2]);
        acc++;
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_accepted", acc, 32'd2);
    step();
    out_ready = 1'b1;
    repeat (4) step();
    chk("bp_drained", exp_q.size(), 32'd0);

    // Reconfigure with both stages full.
    out_ready = 1'b0;
    send(4'b0100, 2'b11);
    send(4'b0011, 2'b00);
    pulse_start();
    chk("drain_cfg_busy", 32'(cfg_busy), 32'd1);
    chk("drain_configured", 32'(configured), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    repeat (2) step();
    chk("drain_held", exp_q.size(), 32'd2);
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain_delivered", exp_q.size(), 32'd0);
    chk("drain_busy_load", 32'(cfg_busy), 32'd1);
    load_image(IMG_B, IMG_A);
    send(4'b0000, 2'b01);
    send(4'b0100, 2'b11);
    send(4'b1011, 2'b01);
    send(4'b1111, 2'b11);
    repeat (4) step();
    chk("imgb_drained", exp_q.size(), 32'd0);

    // Reset in the middle of a load, then reload A over a cleared chain.
    pulse_start();
    for (int j = 0; j < 17; j++) begin
      cfg_bit_valid = 1'b1;
      cfg_bit       = IMG_B[j];
      step();
    end
    cfg_bit_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_configured", 32'(configured), 32'd0);
    chk("midrst_cfg_busy", 32'(cfg_busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_cfg_sout", 32'(cfg_sout), 32'd0);
    pulse_start();
    load_image(IMG_A, '0);
    send(4'b0001, 2'b01);
    send(4'b0100, 2'b11);
    send(4'b0111, 2'b11);
    repeat (4) step();
    chk("reload_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
